// File: rtl/iir_output_decimator_pkg.sv
`default_nettype none
// ============================================================================
// iir_output_decimator_pkg : shared arithmetic helpers for the analogue chain
// Rev 1.0
// ============================================================================
package iir_output_decimator_pkg;

  localparam int FN_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // Round half up, then arithmetic shift right; shift <= 0 is a passthrough.
  function automatic logic signed [FN_W-1:0] round_shift(input logic signed [FN_W-1:0] value,
                                                         input int shift);
    logic signed [FN_W-1:0] half;
    if (shift <= 0) return value;
    half = 64'sd1 <<< (shift - 1);
    return (value + half) >>> shift;
  endfunction

  function automatic logic signed [FN_W-1:0] saturate(input logic signed [FN_W-1:0] value,
                                                      input int width);
    logic signed [FN_W-1:0] hi;
    logic signed [FN_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iir_output_decimator_sample_fifo2.sv
`default_nettype none
// ============================================================================
// sample_fifo2 : 2-entry registered valid/ready FIFO, drops pushes when full
// Rev 1.0
// ============================================================================
module sample_fifo2
  import iir_output_decimator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             drop_o
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             valid_q, valid_d;
  logic             w_pop;

  assign w_pop   = valid_q && ready_i;
  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign full_o  = (count_q == 2'd2);

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    drop_o  = 1'b0;
    case ({push_i, w_pop})
      2'b10: begin
        case (count_q)
          2'd0: begin head_d = push_data_i; count_d = 2'd1; end
          2'd1: begin tail_d = push_data_i; count_d = 2'd2; end
          default: drop_o = 1'b1;
        endcase
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the popped slot makes room even when full.
        if (count_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iir_output_decimator.sv
`default_nettype none
// ============================================================================
// iir_output_decimator : boxcar 2^k average, round/saturate, 2-deep output
// Rev 1.0
// ============================================================================
module iir_output_decimator
  import iir_output_decimator_pkg::*;
#(
  parameter int IN_WIDTH   = 12,
  parameter int OUT_WIDTH  = 8,
  parameter int MAX_LOG2   = 8,
  parameter int LOG2_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic [LOG2_WIDTH-1:0] decim_log2,
  input  logic                  ovf_clr,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [MAX_LOG2-1:0]   block_phase
);

  localparam int                    ACC_W     = IN_WIDTH + MAX_LOG2;
  localparam logic [LOG2_WIDTH-1:0] MAX_SHIFT = LOG2_WIDTH'(MAX_LOG2);

  logic [LOG2_WIDTH-1:0]   shift_q, shift_d;
  logic [MAX_LOG2-1:0]     phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    overflow_q, overflow_d;

  logic [LOG2_WIDTH-1:0]   w_dlog_clamped;
  logic [LOG2_WIDTH-1:0]   w_shift;
  logic [MAX_LOG2-1:0]     w_phase_end;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_last;
  logic                    w_push;
  logic [OUT_WIDTH-1:0]    w_result;
  logic                    w_fifo_full;
  logic                    w_fifo_drop;

  assign w_dlog_clamped = (decim_log2 > MAX_SHIFT) ? MAX_SHIFT : decim_log2;
  // The first sample of a block uses the live exponent; later ones the latched one.
  assign w_shift        = (phase_q == '0) ? w_dlog_clamped : shift_q;
  assign w_phase_end    = MAX_LOG2'((32'd1 << w_shift) - 32'd1);
  assign w_last         = (phase_q == w_phase_end);
  assign w_push         = in_valid && w_last;

  assign w_sum = (phase_q == '0) ? ACC_W'($signed(in_data))
                                 : acc_q + ACC_W'($signed(in_data));

  assign w_result = OUT_WIDTH'(saturate(round_shift(FN_W'(w_sum),
                                                    int'(w_shift) + IN_WIDTH - OUT_WIDTH),
                                        OUT_WIDTH));

  always_comb begin
    shift_d    = shift_q;
    phase_d    = phase_q;
    acc_d      = acc_q;
    overflow_d = overflow_q;
    if (in_valid) begin
      if (phase_q == '0) shift_d = w_dlog_clamped;
      acc_d   = w_sum;
      phase_d = w_last ? '0 : phase_q + MAX_LOG2'(1);
    end
    if (w_fifo_drop && w_fifo_full) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q    <= w_dlog_clamped;
      phase_q    <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  sample_fifo2 #(
    .WIDTH(OUT_WIDTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (w_push),
    .push_data_i(w_result),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .full_o     (w_fifo_full),
    .drop_o     (w_fifo_drop)
  );

  assign overflow    = overflow_q;
  assign block_phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_output_decimator.sv
`default_nettype none
// ============================================================================
// tb_iir_output_decimator : directed + random stimulus against a sample model
// Rev 1.0
// ============================================================================
module tb_iir_output_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic [3:0]  decim_log2;
  logic        ovf_clr;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        overflow;
  logic [7:0]  block_phase;

  always #5 clk = ~clk;

  iir_output_decimator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .decim_log2 (decim_log2),
    .ovf_clr    (ovf_clr),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .block_phase(block_phase)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a block is a list of 2^s samples; results queue up to two deep.
  int     m_cnt = 0;
  int     m_s   = 0;
  longint m_sum = 0;
  longint mq[$];
  bit     m_ovf = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic longint block_result(input longint sum, input int s);
    int     t;
    longint d;
    longint n;
    longint q;
    t = s + 4;
    d = longint'(1) << t;
    n = sum + d / 2;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic void model_edge(input bit v, input int d, input bit r,
                                     input int dl, input bit clr);
    bit     pop;
    bit     push;
    bit     drop;
    longint res;
    pop  = (mq.size() > 0) && r;
    push = 1'b0;
    drop = 1'b0;
    res  = 0;
    if (v) begin
      if (m_cnt == 0) begin
        m_s   = (dl > 8) ? 8 : dl;
        m_sum = 0;
      end
      m_sum += d;
      m_cnt++;
      if (m_cnt == (1 << m_s)) begin
        res   = block_result(m_sum, m_s);
        push  = 1'b1;
        m_cnt = 0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 2) mq.push_back(res);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic compare_state();
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) chk("out_data", $signed(out_data), mq[0]);
    chk("overflow", overflow, m_ovf);
    chk("block_phase", block_phase, m_cnt);
  endtask

  task automatic cycle(input bit v, input int d, input bit r, input int dl, input bit clr);
    in_valid   = v;
    in_data    = 12'(d);
    out_ready  = r;
    decim_log2 = 4'(dl);
    ovf_clr    = clr;
    @(posedge clk);
    model_edge(v, d, r, dl, clr);
    #1;
    compare_state();
  endtask

  task automatic do_reset(input int dl);
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_data    = 12'd77;
    decim_log2 = 4'(dl);
    out_ready  = 1'b0;
    ovf_clr    = 1'b0;
    @(posedge clk);
    m_cnt = 0;
    m_sum = 0;
    m_ovf = 1'b0;
    mq.delete();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_block_phase", block_phase, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int d;
    int dl;
    rst_n = 1'b0;
    do_reset(0);

    // Passthrough ratio: (x+8)>>4 at the default widths
    cycle(1, 100, 1, 0, 0);
    chk("pass_100", $signed(out_data), 6);
    cycle(1, -5, 1, 0, 0);
    chk("pass_m5", $signed(out_data), 0);
    cycle(1, 2047, 1, 0, 0);
    chk("pass_2047_sat", $signed(out_data), 127);
    cycle(0, 0, 1, 0, 0);

    // Averaging with round half up
    cycle(1, 10, 1, 2, 0);
    cycle(1, 11, 1, 2, 0);
    cycle(1, 12, 1, 2, 0);
    chk("avg_not_yet", out_valid, 0);
    cycle(1, 13, 1, 2, 0);
    chk("avg_valid", out_valid, 1);
    chk("avg_value", $signed(out_data), 1);
    cycle(0, 0, 1, 2, 0);

    // Saturation both ways
    cycle(1, 2047, 1, 1, 0);
    cycle(1, 2047, 1, 1, 0);
    chk("sat_pos", $signed(out_data), 127);
    cycle(1, -2048, 1, 1, 0);
    cycle(1, -2048, 1, 1, 0);
    chk("sat_neg", $signed(out_data), -128);
    cycle(0, 0, 1, 1, 0);

    // Gapped input, ratio change mid-block
    cycle(1, 400, 1, 2, 0);
    cycle(0, 0, 1, 2, 0);
    cycle(1, 400, 1, 2, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(1, 400, 1, 1, 0);
    chk("gap_phase", block_phase, 3);
    cycle(0, 0, 1, 1, 0);
    cycle(1, 400, 1, 1, 0);
    chk("gap_close4", out_valid, 1);
    cycle(1, -300, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(1, -300, 1, 1, 0);
    chk("gap_close2", out_valid, 1);
    cycle(0, 0, 1, 1, 0);

    // Backpressure and overflow
    cycle(1, 30, 0, 0, 0);
    cycle(1, 60, 0, 0, 0);
    cycle(1, 90, 0, 0, 0);
    chk("bp_overflow", overflow, 1);
    chk("bp_head", $signed(out_data), 2);
    cycle(0, 0, 1, 0, 0);
    chk("bp_second", $signed(out_data), 4);
    cycle(0, 0, 1, 0, 0);
    chk("bp_empty", out_valid, 0);
    cycle(0, 0, 0, 0, 1);
    chk("bp_clr", overflow, 0);

    // Full buffer: simultaneous push/pop accepted, drop wins over clear
    cycle(1, 30, 0, 0, 0);
    cycle(1, 60, 0, 0, 0);
    cycle(1, 90, 1, 0, 0);
    chk("full_pushpop_ovf", overflow, 0);
    cycle(1, 120, 0, 0, 1);
    chk("drop_beats_clr", overflow, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 1);

    // Reset mid-block discards the partial sum
    for (int i = 0; i < 5; i++) cycle(1, -2000, 1, 3, 0);
    do_reset(3);
    for (int i = 0; i < 8; i++) cycle(1, 800, 1, 3, 0);
    chk("rst_fresh_block", $signed(out_data), 50);
    cycle(0, 0, 1, 3, 0);

    // Random traffic against the model
    dl = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) dl = int'($urandom_range(0, 9));
      case ($urandom_range(0, 5))
        0:       d = 2047;
        1:       d = -2048;
        default: d = int'($urandom_range(0, 4095)) - 2048;
      endcase
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, dl,
            $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iir_output_decimator.md
Name: iir_output_decimator

Overview:
- Sits directly downstream of the IIR filter output in the analogue front-end chain. Consumes one filtered sample per enabled clock.
- Averages blocks of 2^k consecutive samples using a boxcar accumulate-and-dump.
- Rounds and saturates each block average to the display/capture width.
- Delivers results through a valid/ready stream backed by a 2-entry output buffer, so capture logic can stall without breaking the filter's fixed-rate pipeline.

Parameters:
- IN_WIDTH, 12, width of the signed input sample (matches the filter Y_WIDTH).
- OUT_WIDTH, 8, width of the signed output sample; must be 2..IN_WIDTH.
- MAX_LOG2, 8, maximum decimation exponent; the ratio is 2^decim_log2.
- LOG2_WIDTH, 4, width of the decim_log2 port; must satisfy 2^LOG2_WIDTH > MAX_LOG2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_data holds a new filtered sample this cycle (no backpressure)
- in_data  in  IN_WIDTH  signed filtered sample
- decim_log2  in  LOG2_WIDTH  decimation exponent; values above MAX_LOG2 clamp to MAX_LOG2
- ovf_clr  in  1  clears the sticky overflow flag
- out_valid  out  1  head of the output buffer is valid
- out_data  out  OUT_WIDTH  signed decimated sample
- out_ready  in  1  consumer accepts the head when out_valid && out_ready
- overflow  out  1  sticky: at least one block result was dropped
- block_phase  out  MAX_LOG2  current sample index within the block (debug)

Behaviour:
- Reset: rst_n low at a clk edge clears everything.
  - Accumulator, block_phase, buffer count, out_valid, out_data and overflow all go to 0.
  - The latched shift reloads from decim_log2 (clamped).
  - Reset mid-block discards the partial sum. Reset with a full buffer discards both entries.
- Block start: when block_phase==0 and in_valid is high, the block
  - latches shift s = clamp(decim_log2), and
  - loads the accumulator with sign-extended in_data (no add).
  - A change to decim_log2 mid-block has no effect until the next block start.
- Accumulate: each subsequent in_valid cycle adds sign-extended in_data.
  - Accumulator width is IN_WIDTH+MAX_LOG2; it never wraps.
  - Cycles with in_valid low hold all state.
- Dump: the in_valid cycle with block_phase == 2^s-1 completes the block; block_phase then returns to 0.
  - When s==0, every in_valid sample is a complete block.
- Result arithmetic (combinational on the final sum, including the final sample):
  - T = s + (IN_WIDTH-OUT_WIDTH).
  - If T>0, add 2^(T-1) (round half up), then arithmetic right shift by T.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Latency: the result is written to the buffer at the clk edge ending the final sample cycle. out_valid can therefore rise on the next cycle, i.e. 1 cycle after the final sample.
- Output buffer: 2-entry FIFO; out_data and out_valid are driven from registers.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop is always accepted, including when the buffer is full.
  - A push into a full buffer with no pop drops the new result, keeps both entries, and sets overflow.
- overflow: set by a drop; cleared by ovf_clr when no drop occurs in the same cycle. A drop in the same cycle as ovf_clr wins, so overflow is set.
- Ordering: results leave in completion order with no duplication.

Decomposition:
- Shared analogue package holds:
  - function clog2;
  - a saturate(value, width) function;
  - a round_shift(value, shift) function.
  - The filter output conditioning will reuse these later.
- Natural sub-module: sample_fifo2, a generic 2-entry valid/ready register FIFO parameterised by width. It exposes push, full and overflow-on-push-when-full, and is reusable by the trigger path.

Test Plan:
- Passthrough: OUT_WIDTH=12, decim_log2=0, in_valid=1, in_data=100,-5,2047, out_ready=1 -> out_data 100,-5,2047, each 1 cycle after input; overflow stays 0.
- Averaging + rounding: OUT_WIDTH=8, decim_log2=2, input 4 samples of 10,11,12,13 -> sum 46, T=6, (46+32)>>6 = 1 -> single out_data 1, out_valid exactly 1 cycle after the 4th sample.
- Saturation: OUT_WIDTH=8, decim_log2=1, input 2047,2047 -> (4094+16)>>5 = 128 -> saturates to 127; input -2048,-2048 -> -128.
- Gapped input + ratio change: decim_log2=2 with in_valid toggling 1/0, then switch decim_log2 to 1 after the 2nd sample -> the current block still closes after 4 valid samples; following blocks close after 2.
- Backpressure/overflow: decim_log2=0, out_ready=0, push 3 results -> out_valid=1, first two results retained in order, overflow=1. Then out_ready=1 -> exactly those two results pop. Pulse ovf_clr -> overflow=0.
- Reset mid-block: decim_log2=3, 5 samples in, assert rst_n=0 for 1 cycle -> no output. The next 8 samples form a fresh block whose result excludes the earlier 5.
